// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry, field widths, the packed pixel record,
// the drain-side state encoding and the on-screen range test used by the clip filter.
package vga_pkg;

    localparam int H_RES    = 320;
    localparam int V_RES    = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    typedef enum logic [0:0] {
        DRAIN_IDLE   = 1'b0,
        DRAIN_ACTIVE = 1'b1
    } drain_state_e;

    function automatic logic pixel_in_range(input pixel_t p);
        return (int'(p.x) < H_RES) && (int'(p.y) < V_RES);
    endfunction

endpackage

// File: rtl/vga_pixel_queue_if.sv
// Pixel-stream bundle between the renderers (master) and the pixel queue (slave).
interface vga_pixel_queue_if #(parameter int AW = 4);
    import vga_pkg::*;

    logic                in_valid;
    logic [X_W-1:0]      in_x;
    logic [Y_W-1:0]      in_y;
    logic [COLOUR_W-1:0] in_colour;
    logic                in_ready;
    logic                hold;
    logic                flush;
    logic [X_W-1:0]      out_x;
    logic [Y_W-1:0]      out_y;
    logic [COLOUR_W-1:0] out_colour;
    logic                out_plot;
    logic [AW:0]         level;
    logic                empty;

    modport master (
        output in_valid, in_x, in_y, in_colour, hold, flush,
        input  in_ready, out_x, out_y, out_colour, out_plot, level, empty
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour, hold, flush,
        output in_ready, out_x, out_y, out_colour, out_plot, level, empty
    );

endinterface

// File: rtl/pixel_sync_fifo.sv
// Generic DEPTH-entry synchronous pixel FIFO with wrapping pointers, occupancy,
// full/empty flags and a clear that outranks both write and read.
module pixel_sync_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr_en,
    input  pixel_t      wr_data,
    input  logic        rd_en,
    output pixel_t      rd_data,
    output logic [AW:0] level,
    output logic        full,
    output logic        empty
);

    pixel_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     level_r;
    logic            wr_ok_s;
    logic            rd_ok_s;

    assign full    = (level_r == (AW+1)'(DEPTH));
    assign empty   = (level_r == {(AW+1){1'b0}});
    assign wr_ok_s = wr_en && !full && !clear;
    assign rd_ok_s = rd_en && !empty && !clear;
    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;

    // Storage array; needs no reset because pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (rd_ok_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_queue.sv
// Elastic pixel-write buffer feeding the vga_adapter plot port, with hold/flush control.
// Define PIX_CLIP_EN to silently drop accepted pixels that fall outside the screen.
module vga_pixel_queue
    import vga_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    vga_pixel_queue_if.slave   q
);

    pixel_t       in_pix_s;
    pixel_t       head_s;
    pixel_t       out_pix_r;
    logic         out_plot_r;
    logic         push_s;
    logic         store_s;
    logic         pop_s;
    logic [AW:0]  level_s;
    logic         full_s;
    logic         empty_s;
    drain_state_e state_r;
    drain_state_e state_s;

    assign in_pix_s = {q.in_x, q.in_y, q.in_colour};

    // Handshake and drain decisions; flush outranks both sides.
    always_comb begin
        push_s = q.in_valid && !full_s && !q.flush;
`ifdef PIX_CLIP_EN
        store_s = push_s && pixel_in_range(in_pix_s);
`else
        store_s = push_s;
`endif
        pop_s = !q.hold && !empty_s && !q.flush;
    end

    pixel_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (q.flush),
        .wr_en   (store_s),
        .wr_data (in_pix_s),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .level   (level_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Adapter-facing register: coordinates hold their last value between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pix_r  <= {{X_W{1'b0}}, {Y_W{1'b0}}, COLOUR_BLACK};
            out_plot_r <= 1'b0;
        end else if (pop_s) begin
            out_pix_r  <= head_s;
            out_plot_r <= 1'b1;
        end else begin
            out_plot_r <= 1'b0;
        end
    end

    // Drain state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= DRAIN_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Drain next-state: DRAIN lasts while entries remain and nothing stalls it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            DRAIN_IDLE: begin
                if (!empty_s && !q.hold && !q.flush) state_s = DRAIN_ACTIVE;
                else                                 state_s = DRAIN_IDLE;
            end
            DRAIN_ACTIVE: begin
                if (q.flush || q.hold || empty_s)
                    state_s = DRAIN_IDLE;
                else if (pop_s && !store_s && (level_s == {{AW{1'b0}}, 1'b1}))
                    state_s = DRAIN_IDLE;
                else
                    state_s = DRAIN_ACTIVE;
            end
            default: state_s = DRAIN_IDLE;
        endcase
    end

    assign q.in_ready   = !full_s;
    assign q.level      = level_s;
    assign q.empty      = empty_s;
    assign q.out_x      = out_pix_r.x;
    assign q.out_y      = out_pix_r.y;
    assign q.out_colour = out_pix_r.colour;
    assign q.out_plot   = out_plot_r;

endmodule

// File: tb/tb_vga_pixel_queue.sv
// Directed self-checking bench for vga_pixel_queue; expectations follow PIX_CLIP_EN.
module tb_vga_pixel_queue;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   plot_cnt;
    int   plot_x [$];

    vga_pixel_queue_if #(.AW(4)) vif ();

    vga_pixel_queue #(.DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input int x, input int y, input int c);
        vif.in_valid  = v;
        vif.in_x      = 9'(x);
        vif.in_y      = 8'(y);
        vif.in_colour = 3'(c);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        vif.hold  = 1'b0;
        vif.flush = 1'b0;
        offer(1'b0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_level", 32'(vif.level), 32'd0);
        chk("rst_empty", 32'(vif.empty), 32'd1);
        chk("rst_plot", 32'(vif.out_plot), 32'd0);
        chk("rst_x", 32'(vif.out_x), 32'd0);
        chk("rst_ready", 32'(vif.in_ready), 32'd1);

        // Single pixel latency
        offer(1'b1, 146, 220, 2);
        tick();
        offer(1'b0, 0, 0, 0);
        chk("lat_level1", 32'(vif.level), 32'd1);
        chk("lat_noplot", 32'(vif.out_plot), 32'd0);
        tick();
        chk("lat_plot", 32'(vif.out_plot), 32'd1);
        chk("lat_x", 32'(vif.out_x), 32'd146);
        chk("lat_y", 32'(vif.out_y), 32'd220);
        chk("lat_col", 32'(vif.out_colour), 32'd2);
        chk("lat_level0", 32'(vif.level), 32'd0);
        tick();
        chk("lat_onecycle", 32'(vif.out_plot), 32'd0);
        chk("lat_xkeep", 32'(vif.out_x), 32'd146);

        // Fill under hold
        vif.hold = 1'b1;
        plot_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            offer(1'b1, i, 5, 1);
            tick();
            if (vif.out_plot) plot_cnt++;
        end
        offer(1'b1, 16, 5, 1);
        tick();
        tick();
        if (vif.out_plot) plot_cnt++;
        chk("hold_level16", 32'(vif.level), 32'd16);
        chk("hold_ready0", 32'(vif.in_ready), 32'd0);
        chk("hold_noplot", 32'(plot_cnt), 32'd0);
        vif.hold = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            tick();
            chk("drain_plot", 32'(vif.out_plot), 32'd1);
            chk("drain_x", 32'(vif.out_x), 32'(k));
            chk("drain_y", 32'(vif.out_y), 32'd5);
            if (k == 0) chk("drain_lvl15a", 32'(vif.level), 32'd15);
            if (k == 1) begin
                chk("drain_lvl15b", 32'(vif.level), 32'd15);
                offer(1'b0, 0, 0, 0);
            end
        end
        chk("drain_level0", 32'(vif.level), 32'd0);
        tick();
        chk("drain_done", 32'(vif.out_plot), 32'd0);

        // Streaming 40 pixels
        for (int i = 0; i < 40; i++) begin
            offer(1'b1, 100 + i, i, i % 8);
            tick();
            if (i >= 1) begin
                chk("strm_plot", 32'(vif.out_plot), 32'd1);
                chk("strm_x", 32'(vif.out_x), 32'(99 + i));
                chk("strm_level", 32'(vif.level), 32'd1);
            end
        end
        offer(1'b0, 0, 0, 0);
        tick();
        chk("strm_last_x", 32'(vif.out_x), 32'd139);
        chk("strm_last_col", 32'(vif.out_colour), 32'd7);
        chk("strm_level0", 32'(vif.level), 32'd0);

        // Flush beats a simultaneous push
        vif.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 50 + i, 7, 3);
            tick();
        end
        chk("fl_level5", 32'(vif.level), 32'd5);
        offer(1'b1, 200, 9, 4);
        vif.flush = 1'b1;
        tick();
        vif.flush = 1'b0;
        vif.hold  = 1'b0;
        offer(1'b0, 0, 0, 0);
        chk("fl_level0", 32'(vif.level), 32'd0);
        chk("fl_empty", 32'(vif.empty), 32'd1);
        chk("fl_noplot", 32'(vif.out_plot), 32'd0);
        chk("fl_ready", 32'(vif.in_ready), 32'd1);
        tick();
        chk("fl_noplot2", 32'(vif.out_plot), 32'd0);
        chk("fl_notaccepted", 32'(vif.level), 32'd0);

        // Screen-edge pixels
        plot_x.delete();
        offer(1'b1, 320, 10, 1);
        tick();
        if (vif.out_plot) plot_x.push_back(int'(vif.out_x));
        offer(1'b1, 10, 240, 1);
        tick();
        if (vif.out_plot) plot_x.push_back(int'(vif.out_x));
        offer(1'b1, 319, 239, 5);
        tick();
        if (vif.out_plot) plot_x.push_back(int'(vif.out_x));
        offer(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (vif.out_plot) plot_x.push_back(int'(vif.out_x));
        end
`ifdef PIX_CLIP_EN
        chk("clip_count", 32'(plot_x.size()), 32'd1);
        if (plot_x.size() == 1) chk("clip_x0", 32'(plot_x[0]), 32'd319);
`else
        chk("clip_count", 32'(plot_x.size()), 32'd3);
        if (plot_x.size() == 3) begin
            chk("clip_x0", 32'(plot_x[0]), 32'd320);
            chk("clip_x1", 32'(plot_x[1]), 32'd10);
            chk("clip_x2", 32'(plot_x[2]), 32'd319);
        end
`endif
        chk("clip_last_y", 32'(vif.out_y), 32'd239);

        // Reset while draining
        vif.hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 30 + i, 40, 6);
            tick();
        end
        offer(1'b0, 0, 0, 0);
        chk("rd_level8", 32'(vif.level), 32'd8);
        vif.hold = 1'b0;
        tick();
        chk("rd_draining", 32'(vif.out_plot), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rd_noplot", 32'(vif.out_plot), 32'd0);
        chk("rd_level0", 32'(vif.level), 32'd0);
        chk("rd_empty", 32'(vif.empty), 32'd1);
        chk("rd_x0", 32'(vif.out_x), 32'd0);
        tick();
        chk("rd_ready", 32'(vif.in_ready), 32'd1);
        chk("rd_noplot2", 32'(vif.out_plot), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
